// File: rtl/multiword_addsub_ctrl.sv
// Sequences a WORDS-byte add/subtract over the register file, one byte per cycle,
// LSB first, chaining the inter-byte carry through the external OVERFLOW flag register.
module multiword_addsub_ctrl #(
  parameter int W     = 8,
  parameter int AW    = 4,
  parameter int WORDS = 2
) (
  input  logic          CLK,
  input  logic          init,
  input  logic          start,
  input  logic          sub,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] d_base,
  output logic [AW-1:0] rf_raddr_a,
  output logic [AW-1:0] rf_raddr_b,
  input  logic [W-1:0]  rf_rdata_a,
  input  logic [W-1:0]  rf_rdata_b,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [W-1:0]  rf_wdata,
  output logic          overflow_write,
  output logic          OVERFLOW_IN,
  input  logic          OVERFLOW_OUT,
  output logic          busy,
  output logic          done,
  output logic          carry_out
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          sub_q, sub_d;
  logic [AW-1:0] a_base_q, a_base_d;
  logic [AW-1:0] b_base_q, b_base_d;
  logic [AW-1:0] d_base_q, d_base_d;
  logic          carry_out_q, carry_out_d;

  logic [W-1:0]  bop;
  logic          cin;
  logic [W:0]    sum;

  // Byte 0 takes the operation's own carry-in (1 for subtract); later bytes chain via the flag.
  always_comb begin
    bop = sub_q ? ~rf_rdata_b : rf_rdata_b;
    cin = (idx_q == '0) ? sub_q : OVERFLOW_OUT;
    sum = {1'b0, rf_rdata_a} + {1'b0, bop} + {{W{1'b0}}, cin};
  end

  // NOTE: every output gets a default first, so no path through the block can infer a latch.
  always_comb begin
    rf_raddr_a     = '0;
    rf_raddr_b     = '0;
    rf_waddr       = '0;
    rf_we          = 1'b0;
    rf_wdata       = '0;
    overflow_write = 1'b0;
    OVERFLOW_IN    = 1'b0;
    if (state_q == S_ADD) begin
      rf_raddr_a     = a_base_q + AW'(idx_q);
      rf_raddr_b     = b_base_q + AW'(idx_q);
      rf_waddr       = d_base_q + AW'(idx_q);
      rf_we          = 1'b1;
      rf_wdata       = sum[W-1:0];
      overflow_write = 1'b1;
      OVERFLOW_IN    = sum[W];
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign carry_out = carry_out_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sub_d       = sub_q;
    a_base_d    = a_base_q;
    b_base_d    = b_base_q;
    d_base_d    = d_base_q;
    carry_out_d = carry_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ADD;
          idx_d    = '0;
          sub_d    = sub;
          a_base_d = a_base;
          b_base_d = b_base;
          d_base_d = d_base;
        end
      end
      S_ADD: begin
        if (idx_q == LAST_IDX) begin
          state_d     = S_DONE;
          // Same value the flag register presents during DONE.
          carry_out_d = sum[W];
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or negedge init) begin
    if (!init) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      sub_q       <= 1'b0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      d_base_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sub_q       <= sub_d;
      a_base_q    <= a_base_d;
      b_base_q    <= b_base_d;
      d_base_q    <= d_base_d;
      carry_out_q <= carry_out_d;
    end
  end

endmodule

// File: tb/tb_multiword_addsub_ctrl.sv
// Self-checking bench for multiword_addsub_ctrl: register file and flag register models around
// the DUT, whole-operand arithmetic reference, per-cycle output comparison.
module tb_multiword_addsub_ctrl;

  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int WORDS = 2;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          init = 1'b0;
  logic          start = 1'b0;
  logic          sub = 1'b0;
  logic [AW-1:0] a_base = '0, b_base = '0, d_base = '0;
  logic [AW-1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [W-1:0]  rf_rdata_a, rf_rdata_b, rf_wdata;
  logic          rf_we, overflow_write, OVERFLOW_IN;
  logic          OVERFLOW_OUT;
  logic          busy, done, carry_out;

  logic [W-1:0]  mem [DEPTH];
  logic          flag = 1'b0;
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_waddr = '0;
  logic [W-1:0]  tb_wdata = '0;
  int            wr_count = 0;
  int            done_count = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  multiword_addsub_ctrl #(.W(W), .AW(AW), .WORDS(WORDS)) dut (
    .CLK(CLK), .init(init), .start(start), .sub(sub),
    .a_base(a_base), .b_base(b_base), .d_base(d_base),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .overflow_write(overflow_write), .OVERFLOW_IN(OVERFLOW_IN), .OVERFLOW_OUT(OVERFLOW_OUT),
    .busy(busy), .done(done), .carry_out(carry_out)
  );

  // Register file (combinational read) and flag register (clears when not written).
  assign rf_rdata_a   = mem[rf_raddr_a];
  assign rf_rdata_b   = mem[rf_raddr_b];
  assign OVERFLOW_OUT = flag;

  always @(posedge CLK) begin
    flag <= overflow_write ? OVERFLOW_IN : 1'b0;
    if (rf_we) mem[rf_waddr] <= rf_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
    if (rf_we) wr_count <= wr_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [WORDS-1:0]   cy;  // carry out of each byte position
    logic [WORDS*W-1:0] d;   // full result
  } exp_t;

  function automatic exp_t compute_exp(input logic s, input logic [AW-1:0] a, input logic [AW-1:0] b);
    exp_t   r;
    longint va, vb, bop, mask, lm, part, total;
    va = 0;
    vb = 0;
    for (int i = 0; i < WORDS; i++) begin
      va |= longint'(mem[AW'(a + AW'(i))]) << (W * i);
      vb |= longint'(mem[AW'(b + AW'(i))]) << (W * i);
    end
    mask  = (longint'(1) << (W * WORDS)) - 1;
    bop   = s ? (~vb & mask) : vb;
    total = va + bop + longint'(s);
    for (int i = 0; i < WORDS; i++) begin
      lm   = (longint'(1) << (W * (i + 1))) - 1;
      part = (va & lm) + (bop & lm) + longint'(s);
      r.cy[i] = part[W * (i + 1)];
      r.d[W*i +: W] = total[W*i +: W];
    end
    return r;
  endfunction

  // m_phase: cycles elapsed since an accepted start (0 = not operating).
  int            m_phase = 0;
  logic          m_carry = 1'b0;
  logic [AW-1:0] m_a = '0, m_b = '0, m_d = '0;
  exp_t          m_exp = '0;

  always @(posedge CLK or negedge init) begin
    if (!init) begin
      m_phase <= 0;
      m_carry <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_a     <= a_base;
        m_b     <= b_base;
        m_d     <= d_base;
        m_exp   <= compute_exp(sub, a_base, b_base);
      end
    end else if (m_phase <= WORDS) begin
      m_phase <= m_phase + 1;
      if (m_phase == WORDS) m_carry <= m_exp.cy[WORDS-1];
    end else begin
      m_phase <= 0;
    end
  end

  task automatic compare();
    logic adding;
    int   i;
    adding = (m_phase >= 1) && (m_phase <= WORDS);
    i      = adding ? m_phase - 1 : 0;
    check("busy", busy, m_phase != 0);
    check("done", done, m_phase == WORDS + 1);
    check("rf_we", rf_we, adding);
    check("overflow_write", overflow_write, adding);
    check("OVERFLOW_IN", OVERFLOW_IN, adding ? m_exp.cy[i] : 1'b0);
    check("rf_raddr_a", rf_raddr_a, adding ? AW'(m_a + AW'(i)) : '0);
    check("rf_raddr_b", rf_raddr_b, adding ? AW'(m_b + AW'(i)) : '0);
    check("rf_waddr", rf_waddr, adding ? AW'(m_d + AW'(i)) : '0);
    if (adding) check("rf_wdata", rf_wdata, m_exp.d[W*i +: W]);
    else        check("carry_out", carry_out, m_carry);
  endtask

  always @(negedge CLK) compare();

  // ---------------- stimulus ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic load(input logic [AW-1:0] addr, input logic [W-1:0] val);
    tb_we    = 1'b1;
    tb_waddr = addr;
    tb_wdata = val;
    @(posedge CLK); #1;
    tb_we    = 1'b0;
  endtask

  task automatic load16(input logic [AW-1:0] addr, input logic [15:0] val);
    load(addr, val[7:0]);
    load(AW'(addr + 1), val[15:8]);
  endtask

  task automatic run_op(input logic s, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] d, output int lat);
    sub    = s;
    a_base = a;
    b_base = b;
    d_base = d;
    start  = 1'b1;
    @(posedge CLK); #1;
    start  = 1'b0;
    lat    = 0;
    while (!done && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("op completes", done, 1'b1);
    @(posedge CLK); #1;
  endtask

  // Hold start high for 'edges' rising edges, then wait for idle; report ops seen.
  task automatic hold_start(input int edges, output int writes, output int dones);
    int wc0, dc0, w;
    wc0    = wr_count;
    dc0    = done_count;
    sub    = 1'b0;
    a_base = 4'd0;
    b_base = 4'd2;
    d_base = 4'd8;
    start  = 1'b1;
    repeat (edges) begin
      @(posedge CLK); #1;
    end
    start = 1'b0;
    w = 0;
    while (busy && w < 30) begin
      @(posedge CLK); #1;
      w++;
    end
    check("returns to idle", busy, 1'b0);
    writes = wr_count - wc0;
    dones  = done_count - dc0;
  endtask

  function automatic bit bases_ok(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d);
    for (int i = 0; i < WORDS; i++)
      for (int j = 0; j < WORDS; j++)
        if (i != j && (AW'(d + AW'(i)) == AW'(a + AW'(j)) || AW'(d + AW'(i)) == AW'(b + AW'(j))))
          return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int lat, writes, dones;
    logic [AW-1:0] a, b, d;
    logic s;

    #12;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset rf_we", rf_we, 1'b0);
    check("reset carry_out", carry_out, 1'b0);
    #10 init = 1'b1;
    @(posedge CLK); #1;

    // 1: 0x01FF + 0x0001 = 0x0200, no carry, done after WORDS further edges
    load16(4'd0, 16'h01FF);
    load16(4'd2, 16'h0001);
    run_op(1'b0, 4'd0, 4'd2, 4'd4, lat);
    check("t1 done latency", lat, WORDS);
    check("t1 mem4", mem[4], 8'h00);
    check("t1 mem5", mem[5], 8'h02);
    check("t1 carry_out", carry_out, 1'b0);

    // 2: 0xFFFF + 0x0001 = 0x0000, carry 1
    load16(4'd0, 16'hFFFF);
    run_op(1'b0, 4'd0, 4'd2, 4'd4, lat);
    check("t2 mem4", mem[4], 8'h00);
    check("t2 mem5", mem[5], 8'h00);
    check("t2 carry_out", carry_out, 1'b1);

    // 6: reset during the first ADD cycle; D must stay untouched, carry_out cleared
    load(4'd10, 8'hAA);
    load(4'd11, 8'hBB);
    load16(4'd0, 16'h01FF);
    sub = 1'b0; a_base = 4'd0; b_base = 4'd2; d_base = 4'd10;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    #1 init = 1'b0;
    @(negedge CLK);
    #1;
    check("t6 busy in reset", busy, 1'b0);
    check("t6 rf_we in reset", rf_we, 1'b0);
    check("t6 carry_out in reset", carry_out, 1'b0);
    #1 init = 1'b1;
    @(posedge CLK); #1;
    check("t6 mem10 kept", mem[10], 8'hAA);
    check("t6 mem11 kept", mem[11], 8'hBB);
    run_op(1'b0, 4'd0, 4'd2, 4'd10, lat);
    check("t6 rerun mem10", mem[10], 8'h00);
    check("t6 rerun mem11", mem[11], 8'h02);

    // 3: subtraction with and without borrow
    load16(4'd0, 16'h0100);
    run_op(1'b1, 4'd0, 4'd2, 4'd4, lat);
    check("t3a mem4", mem[4], 8'hFF);
    check("t3a mem5", mem[5], 8'h00);
    check("t3a carry_out", carry_out, 1'b1);
    load16(4'd0, 16'h0000);
    run_op(1'b1, 4'd0, 4'd2, 4'd4, lat);
    check("t3b mem4", mem[4], 8'hFF);
    check("t3b mem5", mem[5], 8'hFF);
    check("t3b carry_out", carry_out, 1'b0);

    // 4: address wrap with D in place over A: 0x1234 + 0x01CC = 0x1400
    load(4'd15, 8'h34);
    load(4'd0, 8'h12);
    load(4'd7, 8'hCC);
    load(4'd8, 8'h01);
    run_op(1'b0, 4'd15, 4'd7, 4'd15, lat);
    check("t4 mem15", mem[15], 8'h00);
    check("t4 mem0", mem[0], 8'h14);
    check("t4 carry_out", carry_out, 1'b0);

    // 5: start held through ADD and DONE is ignored; held one cycle longer starts a second op
    hold_start(WORDS + 2, writes, dones);
    check("t5 single writes", writes, WORDS);
    check("t5 single dones", dones, 1);
    hold_start(WORDS + 3, writes, dones);
    check("t5 back2back writes", writes, 2 * WORDS);
    check("t5 back2back dones", dones, 2);

    // Random operations, including in-place aliasing and wrap-around
    for (int n = 0; n < 60; n++) begin
      int tries;
      s = 1'(($urandom() >> 3) & 1);
      tries = 0;
      do begin
        a = AW'($urandom_range(0, DEPTH - 1));
        b = AW'($urandom_range(0, DEPTH - 1));
        case ($urandom_range(0, 3))
          0:       d = a;
          1:       d = b;
          default: d = AW'($urandom_range(0, DEPTH - 1));
        endcase
        tries++;
      end while (!bases_ok(a, b, d) && tries < 100);
      if (!bases_ok(a, b, d)) d = a;
      for (int i = 0; i < WORDS; i++) load(AW'(a + AW'(i)), 8'($urandom_range(0, 255)));
      for (int i = 0; i < WORDS; i++) load(AW'(b + AW'(i)), 8'($urandom_range(0, 255)));
      run_op(s, a, b, d, lat);
      check("random op latency", lat, WORDS);
    end

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
